// File: rtl/text_cursor_writer.sv
// text_cursor_writer
//
// Write-side front end for the character text buffer. Consumes a byte stream,
// keeps a row/column cursor, interprets CR/LF/BS and issues one-cycle write
// commands to the text-buffer RAM. A full-buffer clear (one cell per cycle,
// row-major) runs after reset and whenever clear_req is seen while running.
//
// Ports:
//   clk       - clock, rising edge
//   reset_n   - asynchronous active-low reset
//   rx_valid  - byte available on rx_data
//   rx_data   - incoming character
//   rx_ready  - byte accepted when rx_valid && rx_ready (combinational)
//   clear_req - request a full-buffer clear (level, sampled each cycle)
//   we        - RAM write enable, one-cycle pulse per write
//   w_row     - RAM write row
//   w_col     - RAM write column
//   din       - RAM write data
//   cur_row   - current cursor row
//   cur_col   - current cursor column
//   busy      - clear in progress
module text_cursor_writer #(
  parameter int ROWS       = 4,
  parameter int COLS       = 32,
  parameter int DATA_WIDTH = 8
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          rx_valid,
  input  logic [DATA_WIDTH-1:0]         rx_data,
  output logic                          rx_ready,
  input  logic                          clear_req,
  output logic                          we,
  output logic [$clog2(ROWS)-1:0]       w_row,
  output logic [$clog2(COLS)-1:0]       w_col,
  output logic [DATA_WIDTH-1:0]         din,
  output logic [$clog2(ROWS)-1:0]       cur_row,
  output logic [$clog2(COLS)-1:0]       cur_col,
  output logic                          busy
);

  localparam int RW = $clog2(ROWS);
  localparam int CW = $clog2(COLS);

  // Wrap points are compared explicitly so non-power-of-two sizes work.
  localparam logic [RW-1:0] ROW_LAST = RW'(ROWS - 1);
  localparam logic [CW-1:0] COL_LAST = CW'(COLS - 1);

  localparam logic [DATA_WIDTH-1:0] CH_SPACE = DATA_WIDTH'(8'h20);
  localparam logic [DATA_WIDTH-1:0] CH_TILDE = DATA_WIDTH'(8'h7E);
  localparam logic [DATA_WIDTH-1:0] CH_CR    = DATA_WIDTH'(8'h0D);
  localparam logic [DATA_WIDTH-1:0] CH_LF    = DATA_WIDTH'(8'h0A);
  localparam logic [DATA_WIDTH-1:0] CH_BS    = DATA_WIDTH'(8'h08);

  localparam logic [0:0] ST_RUN   = 1'b0;
  localparam logic [0:0] ST_CLEAR = 1'b1;

  logic [0:0]    state;
  logic [RW-1:0] sweep_row;
  logic [CW-1:0] sweep_col;
  logic          sweep_end;  // last cell has been issued; leave CLEAR next edge

  logic          accept;
  logic          is_print;

  // Candidate cursor positions for each kind of byte.
  logic [RW-1:0] next_row;   // row+1 with wrap
  logic [RW-1:0] adv_row;
  logic [CW-1:0] adv_col;
  logic          bs_move;
  logic [RW-1:0] bs_row;
  logic [CW-1:0] bs_col;

  // Clear wins over a byte offered in the same cycle.
  assign rx_ready = (state == ST_RUN) && !clear_req;
  assign accept   = rx_valid && rx_ready;
  assign is_print = (rx_data >= CH_SPACE) && (rx_data <= CH_TILDE);

  // NOTE: every output of a combinational block gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    next_row = (cur_row == ROW_LAST) ? '0 : cur_row + RW'(1);
    adv_row  = cur_row;
    adv_col  = cur_col + CW'(1);
    bs_move  = 1'b0;
    bs_row   = cur_row;
    bs_col   = cur_col;

    if (cur_col == COL_LAST) begin
      adv_col = '0;
      adv_row = next_row;
    end

    if (cur_col != '0) begin
      bs_move = 1'b1;
      bs_col  = cur_col - CW'(1);
    end else if (cur_row != '0) begin
      bs_move = 1'b1;
      bs_row  = cur_row - RW'(1);
      bs_col  = COL_LAST;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the values from before the edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_CLEAR;
      sweep_row <= '0;
      sweep_col <= '0;
      sweep_end <= 1'b0;
      we        <= 1'b0;
      w_row     <= '0;
      w_col     <= '0;
      din       <= '0;
      cur_row   <= '0;
      cur_col   <= '0;
      busy      <= 1'b1;
    end else begin
      // we is a single-cycle pulse; only a write below raises it again.
      we <= 1'b0;

      case (state)
        ST_CLEAR: begin
          if (sweep_end) begin
            state     <= ST_RUN;
            busy      <= 1'b0;
            sweep_end <= 1'b0;
            cur_row   <= '0;
            cur_col   <= '0;
          end else begin
            we    <= 1'b1;
            w_row <= sweep_row;
            w_col <= sweep_col;
            din   <= '0;
            if (sweep_col == COL_LAST) begin
              sweep_col <= '0;
              if (sweep_row == ROW_LAST) begin
                sweep_row <= '0;
                sweep_end <= 1'b1;
              end else begin
                sweep_row <= sweep_row + RW'(1);
              end
            end else begin
              sweep_col <= sweep_col + CW'(1);
            end
          end
        end

        default: begin  // ST_RUN
          if (clear_req) begin
            state     <= ST_CLEAR;
            busy      <= 1'b1;
            sweep_row <= '0;
            sweep_col <= '0;
            sweep_end <= 1'b0;
          end else if (accept) begin
            if (is_print) begin
              // Printable bytes write at the cursor before it advances.
              we      <= 1'b1;
              w_row   <= cur_row;
              w_col   <= cur_col;
              din     <= rx_data;
              cur_row <= adv_row;
              cur_col <= adv_col;
            end else if (rx_data == CH_CR) begin
              cur_col <= '0;
            end else if (rx_data == CH_LF) begin
              cur_col <= '0;
              cur_row <= next_row;
            end else if (rx_data == CH_BS) begin
              // Backspace blanks the cell it moves back onto.
              if (bs_move) begin
                we      <= 1'b1;
                w_row   <= bs_row;
                w_col   <= bs_col;
                din     <= CH_SPACE;
                cur_row <= bs_row;
                cur_col <= bs_col;
              end
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_text_cursor_writer.sv
// tb_text_cursor_writer
//
// Directed bench for text_cursor_writer at the default 4x32x8 geometry:
// reset sweep, a table of byte vectors covering printable/CR/LF/BS/other,
// row and buffer wrap, clear-vs-byte priority and reset in mid-sweep.
module tb_text_cursor_writer;

  localparam int ROWS = 4;
  localparam int COLS = 32;
  localparam int DW   = 8;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          rx_valid;
  logic [DW-1:0] rx_data;
  logic          rx_ready;
  logic          clear_req;
  logic          we;
  logic [1:0]    w_row;
  logic [4:0]    w_col;
  logic [DW-1:0] din;
  logic [1:0]    cur_row;
  logic [4:0]    cur_col;
  logic          busy;

  int checks = 0;
  int errors = 0;

  text_cursor_writer #(.ROWS(ROWS), .COLS(COLS), .DATA_WIDTH(DW)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .rx_valid  (rx_valid),
    .rx_data   (rx_data),
    .rx_ready  (rx_ready),
    .clear_req (clear_req),
    .we        (we),
    .w_row     (w_row),
    .w_col     (w_col),
    .din       (din),
    .cur_row   (cur_row),
    .cur_col   (cur_col),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    logic       exp_we;
    logic [1:0] wr;
    logic [4:0] wc;
    logic [7:0] wd;
    logic [1:0] cr;
    logic [4:0] cc;
  } vec_t;

  vec_t vecs[23];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expect n consecutive zero writes in row-major order starting at (0,0).
  task automatic check_sweep(input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      check($sformatf("sweep[%0d] {we,row,col,din}", i),
            {19'd0, we, w_row, w_col, din},
            {19'd0, 1'b1, 2'(i / COLS), 5'(i % COLS), 8'h00});
      check($sformatf("sweep[%0d] busy/ready", i), {30'd0, busy, rx_ready}, 32'h2);
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, " write outputs"}, {19'd0, we, w_row, w_col, din}, 32'd0);
    check({tag, " cursor"}, {25'd0, cur_row, cur_col}, 32'd0);
    check({tag, " busy/ready"}, {30'd0, busy, rx_ready}, 32'h2);
  endtask

  // Send one byte and check the resulting write and cursor.
  task automatic send(input string name, input logic [7:0] b, input logic exp_we,
                      input logic [1:0] wr, input logic [4:0] wc, input logic [7:0] wd,
                      input logic [1:0] cr, input logic [4:0] cc);
    rx_valid = 1'b1;
    rx_data  = b;
    tick();
    rx_valid = 1'b0;
    if (exp_we)
      check({name, " write"}, {19'd0, we, w_row, w_col, din}, {19'd0, 1'b1, wr, wc, wd});
    else
      check({name, " no write"}, {31'd0, we}, 32'd0);
    check({name, " cursor"}, {25'd0, cur_row, cur_col}, {25'd0, cr, cc});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vecs[0]  = '{8'h41, 1'b1, 2'd0, 5'd0,  8'h41, 2'd0, 5'd1};
    vecs[1]  = '{8'h42, 1'b1, 2'd0, 5'd1,  8'h42, 2'd0, 5'd2};
    vecs[2]  = '{8'h0D, 1'b0, 2'd0, 5'd0,  8'h00, 2'd0, 5'd0};
    vecs[3]  = '{8'h08, 1'b0, 2'd0, 5'd0,  8'h00, 2'd0, 5'd0};
    vecs[4]  = '{8'h0A, 1'b0, 2'd0, 5'd0,  8'h00, 2'd1, 5'd0};
    vecs[5]  = '{8'h08, 1'b1, 2'd0, 5'd31, 8'h20, 2'd0, 5'd31};
    vecs[6]  = '{8'h43, 1'b1, 2'd0, 5'd31, 8'h43, 2'd1, 5'd0};
    vecs[7]  = '{8'h0A, 1'b0, 2'd0, 5'd0,  8'h00, 2'd2, 5'd0};
    vecs[8]  = '{8'h20, 1'b1, 2'd2, 5'd0,  8'h20, 2'd2, 5'd1};
    vecs[9]  = '{8'h7E, 1'b1, 2'd2, 5'd1,  8'h7E, 2'd2, 5'd2};
    vecs[10] = '{8'h7F, 1'b0, 2'd0, 5'd0,  8'h00, 2'd2, 5'd2};
    vecs[11] = '{8'h1F, 1'b0, 2'd0, 5'd0,  8'h00, 2'd2, 5'd2};
    vecs[12] = '{8'h61, 1'b1, 2'd2, 5'd2,  8'h61, 2'd2, 5'd3};
    vecs[13] = '{8'h62, 1'b1, 2'd2, 5'd3,  8'h62, 2'd2, 5'd4};
    vecs[14] = '{8'h63, 1'b1, 2'd2, 5'd4,  8'h63, 2'd2, 5'd5};
    vecs[15] = '{8'h0D, 1'b0, 2'd0, 5'd0,  8'h00, 2'd2, 5'd0};
    vecs[16] = '{8'h0A, 1'b0, 2'd0, 5'd0,  8'h00, 2'd3, 5'd0};
    vecs[17] = '{8'h0A, 1'b0, 2'd0, 5'd0,  8'h00, 2'd0, 5'd0};
    vecs[18] = '{8'h07, 1'b0, 2'd0, 5'd0,  8'h00, 2'd0, 5'd0};
    vecs[19] = '{8'h0A, 1'b0, 2'd0, 5'd0,  8'h00, 2'd1, 5'd0};
    vecs[20] = '{8'h64, 1'b1, 2'd1, 5'd0,  8'h64, 2'd1, 5'd1};
    vecs[21] = '{8'h08, 1'b1, 2'd1, 5'd0,  8'h20, 2'd1, 5'd0};
    vecs[22] = '{8'h08, 1'b1, 2'd0, 5'd31, 8'h20, 2'd0, 5'd31};

    reset_n   = 1'b0;
    rx_valid  = 1'b0;
    rx_data   = 8'h00;
    clear_req = 1'b0;

    // Reset state, then the power-on sweep.
    #12;
    check_reset_values("reset");
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    check_sweep(ROWS * COLS);
    tick();
    check("post-sweep we", {31'd0, we}, 32'd0);
    check("post-sweep busy/ready", {30'd0, busy, rx_ready}, 32'h1);
    check("post-sweep cursor", {25'd0, cur_row, cur_col}, 32'd0);

    // Back-to-back table stream.
    rx_valid = 1'b1;
    for (int i = 0; i < 23; i++) begin
      rx_data = vecs[i].data;
      tick();
      if (vecs[i].exp_we)
        check($sformatf("vec[%0d] write", i), {19'd0, we, w_row, w_col, din},
              {19'd0, 1'b1, vecs[i].wr, vecs[i].wc, vecs[i].wd});
      else
        check($sformatf("vec[%0d] no write", i), {31'd0, we}, 32'd0);
      check($sformatf("vec[%0d] cursor", i), {25'd0, cur_row, cur_col},
            {25'd0, vecs[i].cr, vecs[i].cc});
    end
    rx_valid = 1'b0;
    tick();
    check("idle we", {31'd0, we}, 32'd0);

    // Buffer wrap from (3,31): walk to row 3, fill 31 cells, then wrap.
    send("lf1", 8'h0A, 1'b0, 2'd0, 5'd0, 8'h00, 2'd1, 5'd0);
    send("lf2", 8'h0A, 1'b0, 2'd0, 5'd0, 8'h00, 2'd2, 5'd0);
    send("lf3", 8'h0A, 1'b0, 2'd0, 5'd0, 8'h00, 2'd3, 5'd0);
    rx_valid = 1'b1;
    rx_data  = 8'h30;
    repeat (31) tick();
    rx_valid = 1'b0;
    check("row3 fill cursor", {25'd0, cur_row, cur_col}, {25'd0, 2'd3, 5'd31});
    send("wrap 0x44", 8'h44, 1'b1, 2'd3, 5'd31, 8'h44, 2'd0, 5'd0);
    send("move 0x45", 8'h45, 1'b1, 2'd0, 5'd0, 8'h45, 2'd0, 5'd1);

    // Clear request beats a simultaneously offered byte.
    rx_valid  = 1'b1;
    rx_data   = 8'h41;
    clear_req = 1'b1;
    #1;
    check("clear-vs-byte rx_ready", {31'd0, rx_ready}, 32'd0);
    tick();
    clear_req = 1'b0;
    check("clear entry we", {31'd0, we}, 32'd0);
    check("clear entry busy", {31'd0, busy}, 32'd1);
    check("clear entry cursor", {25'd0, cur_row, cur_col}, {25'd0, 2'd0, 5'd1});
    check_sweep(ROWS * COLS);
    tick();
    check("clear exit we", {31'd0, we}, 32'd0);
    check("clear exit busy/ready", {30'd0, busy, rx_ready}, 32'h1);
    check("clear exit cursor", {25'd0, cur_row, cur_col}, 32'd0);
    tick();
    rx_valid = 1'b0;
    check("held byte write", {19'd0, we, w_row, w_col, din}, {19'd0, 1'b1, 2'd0, 5'd0, 8'h41});
    check("held byte cursor", {25'd0, cur_row, cur_col}, {25'd0, 2'd0, 5'd1});

    // Reset while the sweep is writing cell (2,7).
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    check_sweep(2 * COLS + 8);
    #2;
    reset_n = 1'b0;
    #1;
    check_reset_values("mid-sweep reset");
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    check_sweep(ROWS * COLS);
    tick();
    check("restart exit busy/ready", {30'd0, busy, rx_ready}, 32'h1);
    send("after restart", 8'h5A, 1'b1, 2'd0, 5'd0, 8'h5A, 2'd0, 5'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
